// File: rtl/arf_pkg.sv
// arf_pkg: shared constants and types for the ARF frame loader.
//   ARF_DATA_W / ARF_LANES : default sample width and samples per frame
//   arf_sample_t           : one sample
//   arf_frame_t            : one unpacked frame of samples
//   bank_sel_t             : selects one of the two ping-pong banks
package arf_pkg;

  localparam int ARF_DATA_W = 16;
  localparam int ARF_LANES  = 8;

  typedef logic [ARF_DATA_W-1:0] arf_sample_t;
  typedef arf_sample_t           arf_frame_t [ARF_LANES];
  typedef logic                  bank_sel_t;

endpackage

// File: rtl/arf_frame_bank.sv
// arf_frame_bank: one LANES x DATA_W register bank with a full flag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_idx     write wr_data into lane wr_idx
//   wr_data           sample to store
//   set_full          mark the bank as holding a complete frame
//   clr_full          release the bank after the consumer takes it
//   full              bank holds a complete frame
//   lanes             bank contents, lane i at [i*DATA_W +: DATA_W]
module arf_frame_bank #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int IDX_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    set_full,
  input  logic                    clr_full,
  output logic                    full,
  output logic [LANES*DATA_W-1:0] lanes
);

  logic [DATA_W-1:0] mem [LANES];

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      for (int i = 0; i < LANES; i++) mem[i] <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_data;
      // The top never sets and clears the same bank in one cycle: a bank
      // being filled is empty, a bank being popped is full.
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_pack
      assign lanes[gi*DATA_W +: DATA_W] = mem[gi];
    end
  endgenerate

endmodule

// File: rtl/arf_frame_loader.sv
// arf_frame_loader: collects serial samples into LANES-wide frames using two
// ping-pong banks and presents complete frames to the ARF datapath.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_valid/s_ready   sample input handshake
//   flush             drop the partially filled frame (wins over an accept)
//   f_data/f_valid/f_ready   frame output handshake; lane 0 = first sample
//   fill_idx          next lane to be written in the fill bank
//   f_id              (only with ARF_FRAME_ID_EN) 8-bit frame sequence tag
// Optional feature macro: ARF_FRAME_ID_EN.
module arf_frame_loader
  import arf_pkg::*;
#(
  parameter int DATA_W = ARF_DATA_W,
  parameter int LANES  = ARF_LANES,
  parameter int IDX_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    flush,
  output logic [LANES*DATA_W-1:0] f_data,
  output logic                    f_valid,
  input  logic                    f_ready,
  output logic [IDX_W-1:0]        fill_idx
`ifdef ARF_FRAME_ID_EN
  ,
  output logic [7:0]              f_id
`endif
);

  bank_sel_t               wr_ptr_reg;
  bank_sel_t               rd_ptr_reg;
  logic [IDX_W-1:0]        fill_idx_reg;
  logic                    full_vec  [2];
  logic [LANES*DATA_W-1:0] lanes_vec [2];

  logic accept;
  logic complete;
  logic pop;

  // All handshake outputs come straight from registered state, so f_ready
  // never reaches s_ready combinationally.
  assign s_ready  = !full_vec[wr_ptr_reg];
  assign f_valid  = full_vec[rd_ptr_reg];
  assign f_data   = lanes_vec[rd_ptr_reg];
  assign fill_idx = fill_idx_reg;

  assign accept   = s_valid && s_ready && !flush;
  assign complete = accept && (fill_idx_reg == IDX_W'(LANES - 1));
  assign pop      = f_valid && f_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      arf_frame_bank #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .IDX_W  (IDX_W)
      ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept   && (wr_ptr_reg == bank_sel_t'(gi))),
        .wr_idx   (fill_idx_reg),
        .wr_data  (s_data),
        .set_full (complete && (wr_ptr_reg == bank_sel_t'(gi))),
        .clr_full (pop      && (rd_ptr_reg == bank_sel_t'(gi))),
        .full     (full_vec[gi]),
        .lanes    (lanes_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fill_idx_reg <= '0;
    end else begin
      // Stale lanes of a flushed frame need no clearing: every lane is
      // rewritten before the bank can be marked full again.
      if (flush) begin
        fill_idx_reg <= '0;
      end else if (accept) begin
        if (complete) begin
          fill_idx_reg <= '0;
          wr_ptr_reg   <= ~wr_ptr_reg;
        end else begin
          fill_idx_reg <= fill_idx_reg + IDX_W'(1);
        end
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

`ifdef ARF_FRAME_ID_EN
  logic [7:0] frame_cnt_reg;
  logic [7:0] id_tag_reg [2];

  assign f_id = id_tag_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      id_tag_reg[0] <= '0;
      id_tag_reg[1] <= '0;
    end else if (complete) begin
      id_tag_reg[wr_ptr_reg] <= frame_cnt_reg;
      frame_cnt_reg          <= frame_cnt_reg + 8'd1;
    end
  end
`endif

endmodule
